fsm_alu: RTL and testbench

// - Multicycle control FSM for RV64 integer ALU instructions: R-type (add/sub/sll/slt/sltu/xor/srl/sra/or/and) and OP-IMM (addi/slti/.../srai).
// - Decodes register fields from the instruction word and drives the datapath strobes: operand fetch, ALU latch, regfile write, PC advance.
// - Sits between the fetch/decode stage (instruction word, one-hot opcode class) and the shared datapath. Memory and branch paths are held inactive.

---
 rtl/cpu_ctrl_pkg.sv | 33 +++
 rtl/fsm_alu_if.sv | 43 ++++
 rtl/fsm_alu_decode.sv | 27 ++
 rtl/fsm_alu.sv | 90 +++++++++
 tb/tb_fsm_alu.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the multicycle ALU sequencer: state/class
// encodings, opcode-class bit positions and fixed datapath select values.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH_OPS,
    ST_EXEC,
    ST_WRITEBACK
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_RTYPE,
    CLS_OPIMM
  } alu_class_t;

  localparam int unsigned CODE_RTYPE = 12;
  localparam int unsigned CODE_OPIMM = 11;

  localparam logic [1:0] SEL_RD_ALU        = 2'b00;
  localparam logic [2:0] SEL_MEM_EXT_NONE  = 3'b000;
  localparam logic [1:0] SEL_MEM_SIZE_NONE = 2'b00;
  localparam logic [2:0] FUNC3_SR          = 3'b101;

  // R-type wins when both class bits are set.
  function automatic alu_class_t decode_class(input logic [31:0] code);
    if (code[CODE_RTYPE])      return CLS_RTYPE;
    else if (code[CODE_OPIMM]) return CLS_OPIMM;
    else                       return CLS_NONE;
  endfunction

endpackage

// File: rtl/fsm_alu_if.sv
// Control bundle between fetch/decode (master) and the ALU sequencer (slave).
interface fsm_alu_if;
  logic [31:0] ins;
  logic [31:0] code;
  logic        start;
  logic        lu;
  logic        ls;
  logic        eq;

  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [2:0]  func3;
  logic [2:0]  sel_mem_extension;
  logic [1:0]  sel_mem_size;
  logic [1:0]  sel_rd;
  logic        load_pc;
  logic        load_regfile;
  logic        load_rs1;
  logic        load_rs2;
  logic        load_alu;
  logic        sel_pc_next;
  logic        sel_pc_alu;
  logic        sel_alu_a;
  logic        sel_alu_b;
  logic        sub_sra;

  modport master (
    output ins, code, start, lu, ls, eq,
    input  rs1_addr, rs2_addr, rd_addr, func3,
    input  sel_mem_extension, sel_mem_size, sel_rd,
    input  load_pc, load_regfile, load_rs1, load_rs2, load_alu,
    input  sel_pc_next, sel_pc_alu, sel_alu_a, sel_alu_b, sub_sra
  );

  modport slave (
    input  ins, code, start, lu, ls, eq,
    output rs1_addr, rs2_addr, rd_addr, func3,
    output sel_mem_extension, sel_mem_size, sel_rd,
    output load_pc, load_regfile, load_rs1, load_rs2, load_alu,
    output sel_pc_next, sel_pc_alu, sel_alu_a, sel_alu_b, sub_sra
  );
endinterface

// File: rtl/fsm_alu_decode.sv
// ALU operand-B select and subtract/arithmetic-shift modifier from the
// latched instruction class and the relevant instruction bits.
module alu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic       i_bit30,
  input  logic [2:0] i_func3,
  input  alu_class_t i_class,
  output logic       o_sel_alu_b,
  output logic       o_sub_sra
);

  always_comb begin
    o_sel_alu_b = 1'b0;
    o_sub_sra   = 1'b0;
    case (i_class)
      CLS_RTYPE: o_sub_sra = i_bit30;
      CLS_OPIMM: begin
        o_sel_alu_b = 1'b1;
        // bit30 is immediate data for everything except srli/srai
        o_sub_sra   = (i_func3 == FUNC3_SR) && i_bit30;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fsm_alu.sv
// Multicycle control FSM for RV64 integer R-type / OP-IMM instructions:
// IDLE -> FETCH_OPS -> EXEC -> WRITEBACK -> IDLE with Moore strobes.
module fsm_alu
  import cpu_ctrl_pkg::*;
(
  input logic    clk,
  input logic    rst_n,
  fsm_alu_if.slave bus
);

  state_t     r_state;
  state_t     w_next;
  alu_class_t r_class;
  alu_class_t w_class_in;
  logic       w_sel_alu_b;
  logic       w_sub_sra;
  logic       w_unused;

  assign w_class_in = decode_class(bus.code);
  assign w_unused   = ^{bus.lu, bus.ls, bus.eq, bus.code[31:13], bus.code[10:0],
                        bus.ins[31], bus.ins[29:25], bus.ins[6:0]};

  assign bus.rs1_addr = bus.ins[19:15];
  assign bus.rs2_addr = bus.ins[24:20];
  assign bus.rd_addr  = bus.ins[11:7];
  assign bus.func3    = bus.ins[14:12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_class <= CLS_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE) r_class <= w_class_in;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (bus.start && (w_class_in != CLS_NONE)) w_next = ST_FETCH_OPS;
      ST_FETCH_OPS: w_next = ST_EXEC;
      ST_EXEC:      w_next = ST_WRITEBACK;
      ST_WRITEBACK: w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  alu_ctrl_decode u_decode (
    .i_bit30     (bus.ins[30]),
    .i_func3     (bus.ins[14:12]),
    .i_class     (r_class),
    .o_sel_alu_b (w_sel_alu_b),
    .o_sub_sra   (w_sub_sra)
  );

  always_comb begin
    bus.load_pc           = 1'b0;
    bus.load_regfile      = 1'b0;
    bus.load_rs1          = 1'b0;
    bus.load_rs2          = 1'b0;
    bus.load_alu          = 1'b0;
    bus.sel_alu_b         = 1'b0;
    bus.sub_sra           = 1'b0;
    bus.sel_rd            = SEL_RD_ALU;
    bus.sel_mem_extension = SEL_MEM_EXT_NONE;
    bus.sel_mem_size      = SEL_MEM_SIZE_NONE;
    bus.sel_pc_next       = 1'b0;
    bus.sel_pc_alu        = 1'b0;
    bus.sel_alu_a         = 1'b0;
    // ALU modifiers are held across the whole sequence, forced low in IDLE
    if (r_state != ST_IDLE) begin
      bus.sel_alu_b = w_sel_alu_b;
      bus.sub_sra   = w_sub_sra;
    end
    case (r_state)
      ST_FETCH_OPS: begin
        bus.load_rs1 = 1'b1;
        bus.load_rs2 = 1'b1;
      end
      ST_EXEC:      bus.load_alu = 1'b1;
      ST_WRITEBACK: begin
        bus.load_regfile = 1'b1;
        bus.load_pc      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_alu.sv
// Scoreboard bench for fsm_alu: expected per-cycle strobes are queued as
// stimulus is applied and popped as the DUT produces each cycle's outputs.
module tb_fsm_alu;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fsm_alu_if bus ();

  fsm_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       rs1;
    logic       rs2;
    logic       alu;
    logic       rf;
    logic       pc;
    logic       b;
    logic       sub;
    logic [9:0] consts;
  } obs_t;

  obs_t q[$];

  function automatic obs_t sample();
    obs_t o;
    o.rs1    = bus.load_rs1;
    o.rs2    = bus.load_rs2;
    o.alu    = bus.load_alu;
    o.rf     = bus.load_regfile;
    o.pc     = bus.load_pc;
    o.b      = bus.sel_alu_b;
    o.sub    = bus.sub_sra;
    o.consts = {bus.sel_mem_extension, bus.sel_mem_size, bus.sel_rd,
                bus.sel_pc_next, bus.sel_pc_alu, bus.sel_alu_a};
    return o;
  endfunction

  // Reference: st 0=IDLE 1=FETCH_OPS 2=EXEC 3=WRITEBACK
  function automatic obs_t model(input int st, input logic b, input logic s);
    obs_t o = '0;
    case (st)
      1: begin o.rs1 = 1'b1; o.rs2 = 1'b1; o.b = b; o.sub = s; end
      2: begin o.alu = 1'b1; o.b = b; o.sub = s; end
      3: begin o.rf = 1'b1; o.pc = 1'b1; o.b = b; o.sub = s; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic randomize_flags();
    bus.lu = 1'($urandom_range(0, 1));
    bus.ls = 1'($urandom_range(0, 1));
    bus.eq = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst_n = 1'b0;
    bus.ins = 32'h001102B3; bus.code = 32'h0000_1000; bus.start = 1'b1;
    bus.lu = 1'b0; bus.ls = 1'b0; bus.eq = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      q.push_back(model(0, 1'b0, 1'b0));
      o = sample(); e = q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset: got %b expected %b", o, e);
      end
    end
    bus.start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_sequence(input logic [31:0] ins, input logic [31:0] code,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [2:0] f3,
                               input logic b, input logic s, input string name);
    obs_t o, e;
    logic [16:0] fo, fe;
    @(negedge clk);
    bus.ins = ins; bus.code = code; bus.start = 1'b1;
    #1;
    fo = {bus.rs1_addr, bus.rs2_addr, bus.rd_addr, bus.func3};
    fe = {rs1, rs2, rd, f3};
    checks++;
    if (fo !== fe) begin
      failures++;
      $display("FAIL %s fields: got %h expected %h", name, fo, fe);
    end
    for (int st = 1; st <= 4; st++) q.push_back(model(st % 4, b, s));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        bus.start = 1'b0;
        bus.code  = '0;
      end
      randomize_flags();
      o = sample(); e = q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s cycle%0d: got %b expected %b", name, i + 1, o, e);
      end
    end
  endtask

  task automatic test_unsupported(input logic [31:0] code, input string name);
    obs_t o, e;
    @(negedge clk);
    bus.ins = 32'h401103B3; bus.code = code; bus.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      q.push_back(model(0, 1'b0, 1'b0));
      @(posedge clk); #1;
      randomize_flags();
      o = sample(); e = q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s cycle%0d: got %b expected %b", name, i, o, e);
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    @(negedge clk);
    bus.ins = 32'h401103B3; bus.code = 32'h0000_1000; bus.start = 1'b1;
    for (int i = 1; i <= 8; i++) q.push_back(model(i % 4, 1'b0, 1'b1));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      o = sample(); e = q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL back_to_back cycle%0d: got %b expected %b", i + 1, o, e);
      end
    end
    @(negedge clk); bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    @(negedge clk);
    bus.ins = 32'h401103B3; bus.code = 32'h0000_1000; bus.start = 1'b1;
    q.push_back(model(1, 1'b0, 1'b1));
    q.push_back(model(2, 1'b0, 1'b1));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      o = sample(); e = q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_mid pre cycle%0d: got %b expected %b", i + 1, o, e);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    q.push_back(model(0, 1'b0, 1'b0));
    o = sample(); e = q.pop_front();
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL reset_mid async: got %b expected %b", o, e);
    end
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin @(negedge clk); rst_n = 1'b1; end
      q.push_back(model(0, 1'b0, 1'b0));
      @(posedge clk); #1;
      o = sample(); e = q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_mid post cycle%0d: got %b expected %b", i, o, e);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequence(32'h001102B3, 32'h0000_1000, 5'd2,  5'd1,  5'd5,  3'd0, 1'b0, 1'b0, "add");
    test_sequence(32'h00A08313, 32'h0000_0800, 5'd1,  5'd10, 5'd6,  3'd0, 1'b1, 1'b0, "addi");
    test_sequence(32'h401103B3, 32'h0000_1000, 5'd2,  5'd1,  5'd7,  3'd0, 1'b0, 1'b1, "sub");
    test_sequence(32'h405A5513, 32'h0000_0800, 5'd20, 5'd5,  5'd10, 3'd5, 1'b1, 1'b1, "srai");
    test_sequence(32'h005A5513, 32'h0000_0800, 5'd20, 5'd5,  5'd10, 3'd5, 1'b1, 1'b0, "srli");
    test_sequence(32'h40A08313, 32'h0000_0800, 5'd1,  5'd10, 5'd6,  3'd0, 1'b1, 1'b0, "addi_bit30");
    test_sequence(32'h40A08313, 32'h0000_1800, 5'd1,  5'd10, 5'd6,  3'd0, 1'b0, 1'b1, "priority");
    test_unsupported(32'h0000_0000, "code_zero");
    test_unsupported(32'hFFFF_E7FF, "code_other_bits");
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
